func2_sweep_ctrl: RTL and testbench
===================================

# func2_sweep_ctrl

Sequencer that drives the five inputs of a `func2` instance through a programmable range of the 32 input combinations. For each vector it waits a fixed settle time, samples `y`, builds the captured truth table and compares it against a golden table. It sits beside `func2` in self-check and bring-up harnesses. It replaces hand-written per-vector stimulus with a single start/done sweep.

## Interface

Parameters:
- `SETTLE`, default 1: extra wait cycles between applying a vector and sampling `y`. Legal range 0..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a sweep. Accepted only in IDLE.
- `first` in 5: first vector of the sweep. Latched on start.
- `last` in 5: last vector of the sweep. Latched on start.
- `expected` in 32: golden truth table; bit v is the expected `y` for vector v. Latched on start.
- `a`, `b`, `c`, `d`, `e` out 1 each: registered drive to `func2`. Vector v = {a,b,c,d,e}, so `a` = v[4] and `e` = v[0].
- `y` in 1: `func2` output. Treated as combinational from a..e.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse at sweep completion.
- `table_out` out 32: captured `y` values; bit v = `y` sampled for vector v.
- `mismatch_cnt` out 6: number of swept vectors with `y` != `expected[v]`. Range 0..32.
- `fail_valid` out 1: at least one mismatch in the last sweep.
- `first_fail` out 5: first mismatching vector in sweep order. Valid when `fail_valid` = 1.

## Operation

- FSM states: IDLE, WAIT, SAMPLE, DONE.
- IDLE with `start` = 1:
  - latch `first`, `last` and `expected`;
  - set the vector register to `first`;
  - clear `table_out`, `mismatch_cnt`, `fail_valid` and `first_fail`;
  - load the settle counter with `SETTLE`;
  - go to WAIT.
- WAIT: if the counter is 0, go to SAMPLE; otherwise decrement it.
- SAMPLE:
  - write `table_out[v]` <= `y`.
  - If `y` != `expected[v]`: increment `mismatch_cnt`. If `fail_valid` = 0, also set `first_fail` <= v and `fail_valid` <= 1.
  - If v == `last`: go to DONE.
  - Otherwise: v <= v+1 (mod 32, wraps 31->0), reload the counter with `SETTLE`, go to WAIT.
- DONE: assert `done` for one cycle, then go to IDLE.
- Vector count N = ((last - first) mod 32) + 1.
  - `first` == `last`: single vector.
  - `first` > `last`: the sweep wraps through 31 -> 0.
  - A full sweep is `first` = `last` + 1 (mod 32), for example first=0, last=31.
- `a`..`e` always reflect the vector register. They hold the last applied vector after the sweep, until the next start.
- Result outputs hold stable from DONE until the next accepted start.
- Bits of `table_out` outside the swept range read 0.
- `start` is ignored in WAIT, SAMPLE and DONE. There is no queuing.
- `first`, `last` and `expected` may change freely after start; only the latched copies are used.

## Timing

- Reset: state IDLE. Every output is 0: a..e, `busy`, `done`, `table_out`, `mismatch_cnt`, `fail_valid`, `first_fail`. The settle counter is 0.
- Reset during a sweep aborts it immediately. No `done` pulse is produced and results are cleared.
- Cycle numbering: `start` is sampled at edge 0.
- Vector k (0-based) is on a..e from cycle 1 + k·(SETTLE+2). It is sampled in cycle (k+1)·(SETTLE+2).
- Per-vector cost is SETTLE+2 cycles. `y` is stable for SETTLE+1 cycles before it is sampled.
- `busy` is 1 in cycles 1 .. N·(SETTLE+2), i.e. in WAIT and SAMPLE.
- `done` is 1 in cycle N·(SETTLE+2)+1 only, with `busy` = 0.
- Results are final in the `done` cycle.
- The earliest next start is accepted at cycle N·(SETTLE+2)+2.
- Back-to-back sweeps: the throughput gap is 2 cycles (DONE, IDLE).

## Test plan

Common setup: `y` is modelled as the parity of {a,b,c,d,e}, whose truth table is 0x96696996. `SETTLE` = 1 unless stated.

- Full sweep, first=0, last=31, expected=0x96696996, start at cycle 0 -> `done` at cycle 97 only; `table_out` = 0x96696996; `mismatch_cnt` = 0; `fail_valid` = 0; a..e = 5'b11111 afterwards.
- Same sweep with expected=0x96696997 and 0x16696996 -> `mismatch_cnt` = 2; `first_fail` = 0; `fail_valid` = 1.
- Wrap sweep, first=30, last=1 -> vectors 30, 31, 0, 1; `table_out` = 0x80000002; `done` at cycle 13.
- Single vector, first=last=7, SETTLE=0 -> a..e = 00111 in cycle 1; `done` at cycle 3; `table_out` = 0x00000080. A `start` pulse in cycle 2 is ignored.
- Reset mid-sweep: assert `rst` at cycle 20 of a full sweep -> next cycle all outputs 0, state IDLE, no `done`. A new start then sweeps correctly.
- `SETTLE`=3 with a two-cycle delayed `y` model -> no mismatches. Compare `SETTLE`=0 with the same model -> `mismatch_cnt` nonzero.

Source files
------------

// File: rtl/func2_sweep_ctrl.sv
// Sweeps a programmable range of the 32 func2 input vectors, captures y per
// vector into a truth table and counts mismatches against a golden table.
module func2_sweep_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  first,
    input  logic [4:0]  last,
    input  logic [31:0] expected,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    input  logic        y,
    output logic        busy,
    output logic        done,
    output logic [31:0] table_out,
    output logic [5:0]  mismatch_cnt,
    output logic        fail_valid,
    output logic [4:0]  first_fail
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  vec;
    logic [4:0]  last_q;
    logic [31:0] expected_q;
    logic [3:0]  settle_cnt;
    logic        y_wrong;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (settle_cnt == 4'd0) begin
                    state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                busy = 1'b1;
                if (vec == last_q) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign y_wrong = (y != expected_q[vec]);

    // Sweep datapath; the vector register wraps naturally at 5 bits so
    // first > last sweeps through 31 -> 0
    always_ff @(posedge clk) begin
        if (rst) begin
            vec          <= 5'd0;
            last_q       <= 5'd0;
            expected_q   <= 32'd0;
            settle_cnt   <= 4'd0;
            table_out    <= 32'd0;
            mismatch_cnt <= 6'd0;
            fail_valid   <= 1'b0;
            first_fail   <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        vec          <= first;
                        last_q       <= last;
                        expected_q   <= expected;
                        settle_cnt   <= SETTLE_LD;
                        table_out    <= 32'd0;
                        mismatch_cnt <= 6'd0;
                        fail_valid   <= 1'b0;
                        first_fail   <= 5'd0;
                    end
                end
                S_WAIT: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    table_out[vec] <= y;
                    if (y_wrong) begin
                        mismatch_cnt <= mismatch_cnt + 6'd1;
                        if (!fail_valid) begin
                            first_fail <= vec;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (vec != last_q) begin
                        vec        <= vec + 5'd1;
                        settle_cnt <= SETTLE_LD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign a = vec[4];
    assign b = vec[3];
    assign c = vec[2];
    assign d = vec[1];
    assign e = vec[0];

endmodule

// File: tb/tb_func2_sweep_ctrl.sv
// Directed bench for func2_sweep_ctrl: three instances (SETTLE 0, 1, 3) driven
// by a parity func2 model, with a two-cycle delayed y variant.
module tb_func2_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  first;
    logic [4:0]  last;
    logic [31:0] expected;
    logic        start0, start1, start3;
    logic        dly0;

    logic        a0, b0, c0, d0, e0, y0, busy0, done0, fv0;
    logic        a1, b1, c1, d1, e1, y1, busy1, done1, fv1;
    logic        a3, b3, c3, d3, e3, y3, busy3, done3, fv3;
    logic [31:0] table0, table1, table3;
    logic [5:0]  mm0, mm1, mm3;
    logic [4:0]  ff0, ff1, ff3;
    logic [4:0]  vec0, vec1, vec3;

    logic        p0_d1, p0_d2, p3_d1, p3_d2;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          done_at;
    int          done_seen;

    always #5 clk = ~clk;

    assign vec0 = {a0, b0, c0, d0, e0};
    assign vec1 = {a1, b1, c1, d1, e1};
    assign vec3 = {a3, b3, c3, d3, e3};

    // func2 modelled as 5-input parity, optionally seen through two flops
    always @(posedge clk) begin
        p0_d1 <= ^vec0;
        p0_d2 <= p0_d1;
        p3_d1 <= ^vec3;
        p3_d2 <= p3_d1;
    end

    assign y0 = dly0 ? p0_d2 : ^vec0;
    assign y1 = ^vec1;
    assign y3 = p3_d2;

    func2_sweep_ctrl #(.SETTLE(0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .first(first), .last(last),
        .expected(expected), .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .y(y0),
        .busy(busy0), .done(done0), .table_out(table0), .mismatch_cnt(mm0),
        .fail_valid(fv0), .first_fail(ff0)
    );

    func2_sweep_ctrl #(.SETTLE(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .first(first), .last(last),
        .expected(expected), .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .y(y1),
        .busy(busy1), .done(done1), .table_out(table1), .mismatch_cnt(mm1),
        .fail_valid(fv1), .first_fail(ff1)
    );

    func2_sweep_ctrl #(.SETTLE(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .first(first), .last(last),
        .expected(expected), .a(a3), .b(b3), .c(c3), .d(d3), .e(e3), .y(y3),
        .busy(busy3), .done(done3), .table_out(table3), .mismatch_cnt(mm3),
        .fail_valid(fv3), .first_fail(ff3)
    );

    function automatic logic get_done(input int w);
        return (w == 0) ? done0 : (w == 1) ? done1 : done3;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] exp_val);
        vectors++;
        assert (observed === exp_val) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, exp_val);
        end
    endtask

    // Start is sampled at edge 0; returns at the negedge inside cycle 1 with
    // the live inputs scrambled so only the latched copies can matter
    task automatic applyStimulus(input int w, input logic [4:0] f,
                                 input logic [4:0] l, input logic [31:0] ex);
        @(negedge clk);
        first    = f;
        last     = l;
        expected = ex;
        case (w)
            0:       start0 = 1'b1;
            1:       start1 = 1'b1;
            default: start3 = 1'b1;
        endcase
        @(negedge clk);
        cyc      = 1;
        start0   = 1'b0;
        start1   = 1'b0;
        start3   = 1'b0;
        first    = 5'h15;
        last     = 5'h15;
        expected = ~ex;
    endtask

    task automatic waitDone(input int w, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (get_done(w)) begin
                at = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        if (at < 0) begin
            checkOutput("done_timeout", 32'(budget), 32'd0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start0   = 1'b0;
        start1   = 1'b0;
        start3   = 1'b0;
        dly0     = 1'b0;
        first    = 5'd0;
        last     = 5'd0;
        expected = 32'd0;
        repeat (3) @(negedge clk);

        checkOutput("rst_vec", 32'(vec1), 32'd0);
        checkOutput("rst_busy", 32'(busy1), 32'd0);
        checkOutput("rst_done", 32'(done1), 32'd0);
        checkOutput("rst_table", table1, 32'd0);
        checkOutput("rst_mm", 32'(mm1), 32'd0);
        checkOutput("rst_fv_ff", 32'({fv1, ff1}), 32'd0);
        rst = 1'b0;

        $display("[TB] full sweep 0..31");
        applyStimulus(1, 5'd0, 5'd31, 32'h96696996);
        checkOutput("full_busy_c1", 32'(busy1), 32'd1);
        checkOutput("full_vec_c1", 32'(vec1), 32'd0);
        waitDone(1, 200, done_at);
        checkOutput("full_done_cyc", 32'(done_at), 32'd97);
        checkOutput("full_busy_at_done", 32'(busy1), 32'd0);
        checkOutput("full_table", table1, 32'h96696996);
        checkOutput("full_mm", 32'(mm1), 32'd0);
        checkOutput("full_fv", 32'(fv1), 32'd0);
        checkOutput("full_abcde", 32'(vec1), 32'd31);
        @(negedge clk);
        checkOutput("full_done_one_pulse", 32'(done1), 32'd0);

        $display("[TB] full sweep with two golden bits flipped");
        applyStimulus(1, 5'd0, 5'd31, 32'h16696997);
        waitDone(1, 200, done_at);
        checkOutput("mm2_mm", 32'(mm1), 32'd2);
        checkOutput("mm2_fv", 32'(fv1), 32'd1);
        checkOutput("mm2_ff", 32'(ff1), 32'd0);
        checkOutput("mm2_table", table1, 32'h96696996);

        $display("[TB] wrap sweep 30..1");
        applyStimulus(1, 5'd30, 5'd1, 32'h96696996);
        waitDone(1, 50, done_at);
        checkOutput("wrap_done_cyc", 32'(done_at), 32'd13);
        checkOutput("wrap_table", table1, 32'h80000002);
        checkOutput("wrap_mm", 32'(mm1), 32'd0);
        checkOutput("wrap_abcde", 32'(vec1), 32'd1);

        applyStimulus(1, 5'd30, 5'd1, 32'h16696997);
        waitDone(1, 50, done_at);
        checkOutput("wrapfail_mm", 32'(mm1), 32'd2);
        checkOutput("wrapfail_ff", 32'(ff1), 32'd31);
        checkOutput("wrapfail_fv", 32'(fv1), 32'd1);

        $display("[TB] reset in the middle of a sweep");
        applyStimulus(1, 5'd0, 5'd31, 32'h96696996);
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("midrst_table_before", table1, 32'h00000016);
        rst = 1'b1;
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        checkOutput("midrst_vec", 32'(vec1), 32'd0);
        checkOutput("midrst_busy", 32'(busy1), 32'd0);
        checkOutput("midrst_table", table1, 32'd0);
        checkOutput("midrst_mm_fv", 32'({mm1, fv1, ff1}), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 110; i++) begin
            if (done1 || busy1) done_seen++;
            @(negedge clk);
        end
        checkOutput("midrst_no_done", 32'(done_seen), 32'd0);
        applyStimulus(1, 5'd0, 5'd31, 32'h96696996);
        waitDone(1, 200, done_at);
        checkOutput("midrst_resweep_cyc", 32'(done_at), 32'd97);
        checkOutput("midrst_resweep_table", table1, 32'h96696996);

        $display("[TB] single vector, SETTLE=0");
        applyStimulus(0, 5'd7, 5'd7, 32'h96696996);
        checkOutput("single_abcde_c1", 32'(vec0), 32'b00111);
        @(negedge clk);
        cyc++;
        first  = 5'd0;
        last   = 5'd31;
        start0 = 1'b1;
        @(negedge clk);
        cyc++;
        start0 = 1'b0;
        waitDone(0, 10, done_at);
        checkOutput("single_done_cyc", 32'(done_at), 32'd3);
        checkOutput("single_table", table0, 32'h00000080);
        checkOutput("single_mm", 32'(mm0), 32'd0);
        @(negedge clk);
        checkOutput("single_ignored_start", 32'({busy0, done0}), 32'd0);
        checkOutput("single_abcde_hold", 32'(vec0), 32'd7);

        $display("[TB] delayed y, SETTLE=3");
        applyStimulus(3, 5'd0, 5'd31, 32'h96696996);
        waitDone(3, 300, done_at);
        checkOutput("dly3_done_cyc", 32'(done_at), 32'd161);
        checkOutput("dly3_mm", 32'(mm3), 32'd0);
        checkOutput("dly3_table", table3, 32'h96696996);

        $display("[TB] delayed y, SETTLE=0");
        dly0 = 1'b1;
        applyStimulus(0, 5'd0, 5'd31, 32'h96696996);
        waitDone(0, 200, done_at);
        checkOutput("dly0_done_cyc", 32'(done_at), 32'd65);
        checkOutput("dly0_mm", 32'(mm0), 32'd22);
        checkOutput("dly0_fv", 32'(fv0), 32'd1);
        checkOutput("dly0_ff", 32'(ff0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
